// File: rtl/gpu_pkg.sv
// Shared GPU display definitions: VGA 640x480@60 timing defaults, pixel
// index type, 4/4/4 colour struct and the 16-entry CGA palette ROM.
package gpu_pkg;

    // Default 640x480@60 timing, in pixel ticks and lines.
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
    localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

    // Width of the h/v position counters; 11 bits covers 800 and 525.
    localparam int CNT_W = 11;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [3:0]       pix_idx_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Standard 16-colour CGA palette as 12-bit RGB (r in the top nibble).
    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    function automatic rgb444_t palette_lookup(input pix_idx_t idx);
        return rgb444_t'(PALETTE[idx]);
    endfunction

    function automatic rgb444_t grey_lookup(input pix_idx_t idx);
        rgb444_t c;
        c.r = idx;
        c.g = idx;
        c.b = idx;
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA timing generator: 25 MHz pixel tick from the 50 MHz clock, h/v
// position counters and combinational active/sync/frame-begin decodes
// for the current position.
module vga_timing_gen
    import gpu_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output cnt_t h_cnt,
    output cnt_t v_cnt,
    output logic active,
    output logic hs_raw,
    output logic vs_raw,
    output logic frame_begin
);

    localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT_C  = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    logic phase;

    assign tick = phase;

    // Pixel-rate phase toggle and raster position counters advanced on ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            phase <= ~phase;
            if (phase) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    if (v_cnt == V_LAST) begin
                        v_cnt <= '0;
                    end else begin
                        v_cnt <= v_cnt + 1'b1;
                    end
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // Position decodes for the pixel currently addressed by the counters.
    always_comb begin
        active      = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs_raw      = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_raw      = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        frame_begin = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/fb_scanout_reader.sv
// Frame buffer scan-out reader: fetches one 4-bit pixel index per pixel
// tick, maps it to 4/4/4 RGB and drives VGA pins with aligned syncs.
// Optional macro FB_SCANOUT_PALETTE_EN selects the CGA palette ROM;
// without it the index is shown as greyscale.
module fb_scanout_reader
    import gpu_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  pix_idx_t          rd_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vblank,
    output logic              frame_start
);

    localparam cnt_t H_LAST  = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t V_ACT_C = cnt_t'(V_ACTIVE);

    logic              tick;
    cnt_t              h_cnt;
    cnt_t              v_cnt;
    logic              active;
    logic              hs_raw;
    logic              vs_raw;
    logic              frame_begin;
    logic              frame_last;

    logic [ADDR_W-1:0] addr;
    logic              hs1;
    logic              vs1;
    logic              act1;
    rgb444_t           lut_rgb;
    rgb444_t           rgb;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active),
        .hs_raw      (hs_raw),
        .vs_raw      (vs_raw),
        .frame_begin (frame_begin)
    );

    assign frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // Index-to-colour map for the fetched pixel.
    always_comb begin
`ifdef FB_SCANOUT_PALETTE_EN
        lut_rgb = palette_lookup(rd_data);
`else
        lut_rgb = grey_lookup(rd_data);
`endif
    end

    // Address counter, fetch stage and colour/sync output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr        <= '0;
            rd_addr     <= '0;
            rd_en       <= 1'b0;
            hs1         <= 1'b1;
            vs1         <= 1'b1;
            act1        <= 1'b0;
            rgb         <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Single-clk pulse: falls on the following (non-tick) edge.
            frame_start <= tick && frame_begin;
            if (tick) begin
                rd_addr <= addr;
                rd_en   <= active;
                hs1     <= hs_raw;
                vs1     <= vs_raw;
                act1    <= active;
                if (frame_last) begin
                    addr <= '0;
                end else if (active) begin
                    addr <= addr + 1'b1;
                end

                // rd_addr has been stable for two clks, so rd_data now
                // belongs to the pixel captured in stage 1.
                rgb    <= act1 ? lut_rgb : '0;
                vga_hs <= hs1;
                vga_vs <= vs1;
                vblank <= (v_cnt >= V_ACT_C);
            end
        end
    end

    assign vga_r = rgb.r;
    assign vga_g = rgb.g;
    assign vga_b = rgb.b;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed bench for fb_scanout_reader: one full-size 640x480 instance for
// start-up, address, colour and hsync checks, and one scaled-down instance
// (16x8 total raster) for frame-level sync, wrap and mid-frame reset checks.
module tb_fb_scanout_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance
    logic        reset_f = 1'b1;
    logic [18:0] rd_addr_f;
    logic        rd_en_f;
    logic [3:0]  rd_data_f;
    logic [3:0]  r_f, g_f, b_f;
    logic        hs_f, vs_f, vblank_f, fs_f;
    logic        force_f = 1'b0;

    // Scaled instance: 8 active + 2 fp + 3 sync + 3 bp = 16; 4+1+2+1 = 8 lines
    logic        reset_s = 1'b1;
    logic [5:0]  rd_addr_s;
    logic        rd_en_s;
    logic [3:0]  rd_data_s;
    logic [3:0]  r_s, g_s, b_s;
    logic        hs_s, vs_s, vblank_s, fs_s;

    int vec_count  = 0;
    int miscompares = 0;
    int edge_n     = 0;

    fb_scanout_reader u_full (
        .clk         (clk),
        .reset       (reset_f),
        .rd_addr     (rd_addr_f),
        .rd_en       (rd_en_f),
        .rd_data     (rd_data_f),
        .vga_r       (r_f),
        .vga_g       (g_f),
        .vga_b       (b_f),
        .vga_hs      (hs_f),
        .vga_vs      (vs_f),
        .vblank      (vblank_f),
        .frame_start (fs_f)
    );

    fb_scanout_reader #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .ADDR_W   (6)
    ) u_small (
        .clk         (clk),
        .reset       (reset_s),
        .rd_addr     (rd_addr_s),
        .rd_en       (rd_en_s),
        .rd_data     (rd_data_s),
        .vga_r       (r_s),
        .vga_g       (g_s),
        .vga_b       (b_s),
        .vga_hs      (hs_s),
        .vga_vs      (vs_s),
        .vblank      (vblank_s),
        .frame_start (fs_s)
    );

    // Synchronous-read RAM models: data is the low nibble of the address.
    always @(posedge clk) begin
        rd_data_f <= force_f ? 4'hF : rd_addr_f[3:0];
        rd_data_s <= rd_addr_s[3:0];
    end

    function automatic logic [11:0] exp_rgb(input int idx);
        logic [3:0] i;
        i = idx[3:0];
`ifdef FB_SCANOUT_PALETTE_EN
        case (i)
            4'd0:  return 12'h000;
            4'd1:  return 12'h00A;
            4'd2:  return 12'h0A0;
            4'd3:  return 12'h0AA;
            4'd4:  return 12'hA00;
            4'd5:  return 12'hA0A;
            4'd6:  return 12'hA50;
            4'd7:  return 12'hAAA;
            4'd8:  return 12'h555;
            4'd9:  return 12'h55F;
            4'd10: return 12'h5F5;
            4'd11: return 12'h5FF;
            4'd12: return 12'hF55;
            4'd13: return 12'hF5F;
            4'd14: return 12'hFF5;
            default: return 12'hFFF;
        endcase
`else
        return {i, i, i};
`endif
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        edge_n += n;
    endtask

    int hs_fall, hs_rise, vs_fall, vs_rise, fs1, fs2, wrap_edge, wrap_addr;
    bit hs_fell, hs_rose, vs_fell, vs_rose, wrap_seen;

    initial begin
        // ---------------- full-size instance ----------------
        step(3);
        check_val("reset_f", {rd_en_f, rd_addr_f, r_f, g_f, b_f, hs_f, vs_f, vblank_f, fs_f},
                  {1'b0, 19'd0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0});

        reset_f = 1'b0;
        edge_n  = 0;
        step(2);
        check_val("first_en",   {31'd0, rd_en_f}, 32'd1);
        check_val("first_addr", {13'd0, rd_addr_f}, 32'd0);
        check_val("first_fs",   {31'd0, fs_f}, 32'd1);
        step(1);
        check_val("fs_pulse",   {31'd0, fs_f}, 32'd0);
        step(1);
        // Edge 2k+2 issues address k and shows the colour of index k-1.
        for (int k = 1; k <= 16; k++) begin
            check_val("sweep_addr", {13'd0, rd_addr_f}, k);
            check_val("sweep_rgb",  {20'd0, r_f, g_f, b_f}, {20'd0, exp_rgb(k - 1)});
            if (k < 16) step(2);
        end
        force_f = 1'b1;

        while (edge_n < 1602) begin
            step(1);
            if (!hs_fell && !hs_f) begin
                hs_fell = 1'b1;
                hs_fall = edge_n;
            end else if (hs_fell && !hs_rose && hs_f) begin
                hs_rose = 1'b1;
                hs_rise = edge_n;
            end
            if (edge_n == 1000) begin
                check_val("const_f_rgb", {20'd0, r_f, g_f, b_f}, 32'hFFF);
                check_val("const_f_en",  {31'd0, rd_en_f}, 32'd1);
            end
            if (edge_n == 1290) begin
                check_val("hblank_rgb", {20'd0, r_f, g_f, b_f}, 32'h0);
                check_val("hblank_en",  {31'd0, rd_en_f}, 32'd0);
            end
        end
        check_val("line1_addr", {13'd0, rd_addr_f}, 32'd640);
        check_val("line1_en",   {31'd0, rd_en_f}, 32'd1);
        check_val("hs_fall",    hs_fall, 32'd1316);
        check_val("hs_low",     hs_rise - hs_fall, 32'd192);

        // ---------------- scaled instance ----------------
        reset_s = 1'b0;
        edge_n  = 0;
        fs1 = 0; fs2 = 0;
        while (edge_n < 600) begin
            step(1);
            if (fs_s) begin
                if (fs1 == 0) fs1 = edge_n;
                else if (fs2 == 0) fs2 = edge_n;
            end
            if (!vs_fell && !vs_s) begin
                vs_fell = 1'b1;
                vs_fall = edge_n;
            end else if (vs_fell && !vs_rose && vs_s) begin
                vs_rose = 1'b1;
                vs_rise = edge_n;
            end
            if (edge_n == 112)
                check_val("last_fetch", {25'd0, rd_en_s, rd_addr_s}, {25'd0, 1'b1, 6'd31});
            if (edge_n == 114)
                check_val("after_last_en", {31'd0, rd_en_s}, 32'd0);
            if (edge_n == 120)
                check_val("vblank_rgb", {20'd0, r_s, g_s, b_s}, 32'h0);
            if (edge_n > 114 && rd_en_s && !wrap_seen) begin
                wrap_seen = 1'b1;
                wrap_edge = edge_n;
                wrap_addr = int'(rd_addr_s);
            end
            if (edge_n == 128) check_val("vblank_pre",  {31'd0, vblank_s}, 32'd0);
            if (edge_n == 130) check_val("vblank_rise", {31'd0, vblank_s}, 32'd1);
        end
        check_val("fs_first",   fs1, 32'd2);
        check_val("fs_period",  fs2 - fs1, 32'd256);
        check_val("vs_fall",    vs_fall, 32'd164);
        check_val("vs_low",     vs_rise - vs_fall, 32'd64);
        check_val("wrap_edge",  wrap_edge, 32'd258);
        check_val("wrap_addr",  wrap_addr, 32'd0);

        // Mid-line reset (scaled raster line 2, pixel 11) held for 3 clks.
        reset_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_val("mid_reset", {rd_en_s, rd_addr_s, r_s, g_s, b_s, hs_s, vs_s, vblank_s, fs_s},
                      {1'b0, 6'd0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        reset_s = 1'b0;
        step(1);
        check_val("restart_wait", {31'd0, rd_en_s}, 32'd0);
        step(1);
        check_val("restart_fetch", {25'd0, rd_en_s, rd_addr_s}, {25'd0, 1'b1, 6'd0});
        check_val("restart_fs",    {31'd0, fs_s}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
